uart_tx: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx.sv | 127 ++++++++++++
 tb/tb_uart_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART frame definitions used by both the transmitter and the receiver,
// so both ends of a link agree on the line format.
package uart_pack;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    // Default frame format: 16 clocks per bit, 8N1.
    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_PARITY_EN    = 0;
    localparam int UART_PARITY_ODD   = 0;
    localparam int UART_STOP_BITS    = 1;

    localparam logic UART_LINE_IDLE   = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running bit-time counter. A restart realigns it to a new frame, and tick
// pulses once per bit at TICK_AT: bit end for the transmitter, mid-bit for the receiver.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TICK_AT      = CLKS_PER_BIT - 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_TICK = CW'(TICK_AT);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (restart || (cnt_reg == CNT_LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == CNT_TICK);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: takes one byte per valid/ready handshake and serialises it
// as start bit, LSB-first data, optional parity and stop bit(s) on a registered line.
module uart_tx
    import uart_pack::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int PARITY_EN    = UART_PARITY_EN,
    parameter int PARITY_ODD   = UART_PARITY_ODD,
    parameter int STOP_BITS    = UART_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 out,
    output logic                 busy
);

    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    uart_tx_state_t       state_reg, state_next;
    logic [BCW-1:0]       bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_reg;
    logic                 out_reg, out_next;
    logic                 transfer;
    logic                 tick;
    logic [DATA_BITS:0]   par_chain;

    assign transfer = data_valid && (state_reg == IDLE);

    // The counter restarts on the accepting edge, so every bit is a full CLKS_PER_BIT.
    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (transfer),
        .tick    (tick)
    );

    assign par_chain[0] = (PARITY_ODD != 0);
    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_parity
            assign par_chain[gi+1] = par_chain[gi] ^ data_in[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (transfer) state_next = START;
            end
            START: begin
                if (tick) state_next = DATA;
            end
            DATA: begin
                if (tick && (bit_cnt_reg == LAST_DATA)) begin
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick) state_next = STOP;
            end
            STOP: begin
                if (tick && (bit_cnt_reg == LAST_STOP)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_next   = UART_LINE_IDLE;
        busy       = 1'b1;
        data_ready = 1'b0;
        case (state_reg)
            IDLE: begin
                busy       = 1'b0;
                data_ready = 1'b1;
            end
            START:   out_next = UART_START_LEVEL;
            DATA:    out_next = shift_reg[0];
            PARITY:  out_next = parity_reg;
            STOP:    out_next = UART_STOP_LEVEL;
            default: out_next = UART_LINE_IDLE;
        endcase
    end

    // Bit counter serves both data and stop phases; it clears on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            out_reg     <= UART_LINE_IDLE;
        end else begin
            out_reg <= out_next;
            if (transfer) begin
                shift_reg  <= data_in;
                parity_reg <= par_chain[DATA_BITS];
            end else if ((state_reg == DATA) && tick) begin
                shift_reg <= shift_reg >> 1;
            end
            if (state_next != state_reg) begin
                bit_cnt_reg <= '0;
            end else if (tick && ((state_reg == DATA) || (state_reg == STOP))) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    assign out = out_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a default 8N1 instance with a loopback decoder and scoreboard,
// plus even- and odd-parity instances checked bit by bit.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       dv = 1'b0;
    int         sel = 0;

    logic ready0, out0, busy0;
    logic ready_pe, out_pe, busy_pe;
    logic ready_po, out_po, busy_po;
    logic line, rdy, bsy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic       bit_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx u_dflt (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv && (sel == 0)),
        .data_ready(ready0), .out(out0), .busy(busy0)
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv && (sel == 1)),
        .data_ready(ready_pe), .out(out_pe), .busy(busy_pe)
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv && (sel == 2)),
        .data_ready(ready_po), .out(out_po), .busy(busy_po)
    );

    always_comb begin
        case (sel)
            1:       begin line = out_pe; rdy = ready_pe; bsy = busy_pe; end
            2:       begin line = out_po; rdy = ready_po; bsy = busy_po; end
            default: begin line = out0;   rdy = ready0;   bsy = busy0;   end
        endcase
    end

    // Loopback receiver on the default instance, sampling each bit at its centre.
    logic       mon_busy = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;
    logic [7:0] mon_exp;
    always @(negedge clk) begin
        if (rst) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (out0 == 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 8) begin
                checks++;
                if (out0 !== 1'b0) begin
                    errors++;
                    $display("FAIL rx_start: got %b want 0 at cycle %0d", out0, cyc);
                end
            end else if (mon_cnt >= 24 && mon_cnt <= 136 && (mon_cnt % 16) == 8) begin
                mon_byte = {out0, mon_byte[7:1]};
            end else if (mon_cnt == 152) begin
                mon_busy = 1'b0;
                checks++;
                if (out0 !== 1'b1) begin
                    errors++;
                    $display("FAIL rx_stop: got %b want 1 at cycle %0d", out0, cyc);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected: got frame %02h want none", mon_byte);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_byte !== mon_exp) begin
                        errors++;
                        $display("FAIL rx_byte: got %02h want %02h", mon_byte, mon_exp);
                    end else begin
                        $display("rx byte %02h ok at cycle %0d", mon_byte, cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic [7:0] b, output int t);
        int n;
        n = 0;
        sel = s;
        data_in = b;
        dv = 1'b1;
        while (rdy !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        if (rdy !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready=%b want 1 after %0d cycles", rdy, n);
        end
        tick();
        t = cyc;
        dv = 1'b0;
        if (s == 0) exp_q.push_back(b);
        $display("tx sel=%0d byte %02h accepted at cycle %0d", s, b, t);
    endtask

    task automatic check_frame(input int s, input logic [7:0] b, input bit pen,
                               input bit podd, input string name);
        int   t;
        int   nbits;
        logic e;
        bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) bit_q.push_back(b[i]);
        if (pen) bit_q.push_back((^b) ^ podd);
        bit_q.push_back(1'b1);
        nbits = bit_q.size();
        send(s, b, t);
        checks++;
        if (line !== 1'b1 || rdy !== 1'b0 || bsy !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: out/ready/busy=%b%b%b want 101", name, line, rdy, bsy);
        end
        repeat (8) tick();
        for (int k = 0; k < nbits; k++) begin
            e = bit_q.pop_front();
            checks++;
            if (line !== e) begin
                errors++;
                $display("FAIL %s_bit%0d: got %b want %b", name, k, line, e);
            end
            if (k < nbits - 1) repeat (16) tick();
        end
        repeat (7) tick();
        checks++;
        if (rdy !== 1'b0 || bsy !== 1'b1) begin
            errors++;
            $display("FAIL %s_lastcyc: ready/busy=%b%b want 01", name, rdy, bsy);
        end
        tick();
        checks++;
        if (rdy !== 1'b1 || bsy !== 1'b0 || line !== 1'b1) begin
            errors++;
            $display("FAIL %s_end: ready/busy/out=%b%b%b want 101", name, rdy, bsy, line);
        end
        $display("frame %s byte %02h checked, %0d bits", name, b, nbits);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out0 !== 1'b1 || busy0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: out/busy=%b%b want 10", out0, busy0);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (ready0 !== 1'b1 || out0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready/out/busy=%b%b%b want 110", ready0, out0, busy0);
        end
        $display("reset checked");
    endtask

    task automatic test_default();
        check_frame(0, 8'h55, 1'b0, 1'b0, "dflt55");
        check_frame(0, 8'hC9, 1'b0, 1'b0, "dfltC9");
    endtask

    task automatic test_parity();
        check_frame(1, 8'h07, 1'b1, 1'b0, "even07");
        check_frame(2, 8'h07, 1'b1, 1'b1, "odd07");
        check_frame(1, 8'hB4, 1'b1, 1'b0, "evenB4");
    endtask

    task automatic test_back_to_back();
        int t1, t2, n;
        sel = 0;
        data_in = 8'hA3;
        dv = 1'b1;
        n = 0;
        while (rdy !== 1'b1 && n < 500) begin tick(); n++; end
        tick();
        t1 = cyc;
        exp_q.push_back(8'hA3);
        data_in = 8'h3C;
        exp_q.push_back(8'h3C);
        n = 0;
        do begin tick(); n++; end while (rdy !== 1'b1 && n < 400);
        tick();
        t2 = cyc;
        dv = 1'b0;
        checks++;
        if (t2 - t1 != 161) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles want 161", t2 - t1);
        end
        checks++;
        if (line !== 1'b1 || rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_cycle: out/ready=%b%b want 10", line, rdy);
        end
        tick();
        checks++;
        if (line !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start: got %b want 0", line);
        end
        n = 0;
        while (rdy !== 1'b1 && n < 400) begin tick(); n++; end
        repeat (4) tick();
        $display("back-to-back A3/3C transfers at cycles %0d and %0d", t1, t2);
    endtask

    task automatic test_abort();
        int t;
        sel = 0;
        data_in = 8'h8F;
        dv = 1'b1;
        tick();
        t = cyc;
        dv = 1'b0;
        repeat (84) tick();
        checks++;
        if (line !== 1'b0) begin
            errors++;
            $display("FAIL abort_bit4: got %b want 0", line);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (line !== 1'b1 || bsy !== 1'b0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL abort_reset: out/busy/ready=%b%b%b want 101", line, bsy, rdy);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        $display("frame 8F started at cycle %0d aborted by reset", t);
        check_frame(0, 8'hF0, 1'b0, 1'b0, "afterabort");
    endtask

    task automatic test_ignore();
        int t, n, busy_cnt;
        send(0, 8'h5A, t);
        repeat (40) tick();
        data_in = 8'hFF;
        dv = 1'b1;
        tick();
        dv = 1'b0;
        checks++;
        if (rdy !== 1'b0 || bsy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_busy: ready/busy=%b%b want 01", rdy, bsy);
        end
        n = 0;
        while (rdy !== 1'b1 && n < 400) begin tick(); n++; end
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bsy !== 1'b0) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 0) begin
            errors++;
            $display("FAIL ignore_extra_frame: busy for %0d cycles want 0", busy_cnt);
        end
        $display("mid-frame pulse FF ignored during frame 5A");
    endtask

    initial begin
        #(500000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default();
        test_parity();
        test_back_to_back();
        test_abort();
        test_ignore();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bytes left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
